// File: rtl/controller.sv
// Moore microsequencer for the single-bus multi-cycle CPU.
// Decodes the IR opcode and emits per-microstate datapath strobes.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] operationcode,
  output logic [4:0] state,
  output logic [4:0] next_state,
  output logic       wpc,
  output logic       wmar,
  output logic       wir,
  output logic       wt,
  output logic       wmdr,
  output logic       rpc,
  output logic       rt,
  output logic       rc1,
  output logic       rmar,
  output logic       rmdr,
  output logic       rm,
  output logic       wmem,
  output logic       in_mdr1,
  output logic       in_mdr2,
  output logic       out_mdr1,
  output logic       out_mdr2,
  output logic [1:0] inReg,
  output logic       wReg,
  output logic       rReg,
  output logic [2:0] aluOp,
  output logic       ldF
);

  typedef enum logic [4:0] {
    S_RST  = 5'b00000,
    S_F1   = 5'b00001,
    S_F2   = 5'b00010,
    S_F3   = 5'b00011,
    S_F4   = 5'b00100,
    S_DEC  = 5'b00101,
    S_ALU1 = 5'b00110,
    S_ALU2 = 5'b00111,
    S_WB   = 5'b01000,
    S_ALUC = 5'b01001,
    S_LD1  = 5'b01010,
    S_LD2  = 5'b01011,
    S_LD3  = 5'b01100,
    S_ST1  = 5'b01101,
    S_ST2  = 5'b01110,
    S_ST3  = 5'b01111,
    S_JMP  = 5'b10000,
    S_HALT = 5'b11111
  } state_t;

  localparam logic [2:0] ALU_INC  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_RS = 2'b01;
  localparam logic [1:0] SEL_RT = 2'b10;

  logic [4:0] cur;
  logic [4:0] nxt;

  logic op_halt;
  logic op_alu;
  logic op_ld;
  logic op_st;
  logic op_jmp;

  assign op_halt = &operationcode;
  assign op_alu  = ~operationcode[5];
  assign op_ld   = (operationcode[5:4] == 2'b10)
                 & ~operationcode[0];
  assign op_st   = (operationcode[5:4] == 2'b10)
                 & operationcode[0];
  assign op_jmp  = (operationcode[5:4] == 2'b11)
                 & ~op_halt;

  always_ff @(posedge clk) begin
    if (reset) cur <= S_RST;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = S_RST;
    case (cur)
      S_RST:  nxt = S_F1;
      S_F1:   nxt = S_F2;
      S_F2:   nxt = S_F3;
      S_F3:   nxt = S_F4;
      S_F4:   nxt = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          op_halt: nxt = S_HALT;
          op_alu:  nxt = S_ALU1;
          op_ld:   nxt = S_LD1;
          op_st:   nxt = S_ST1;
          op_jmp:  nxt = S_JMP;
          default: nxt = S_RST;
        endcase
      end
      S_ALU1: begin
        if (operationcode[5:4] == 2'b00)
          nxt = S_ALU2;
        else
          nxt = S_ALUC;
      end
      S_ALU2: nxt = S_WB;
      S_WB:   nxt = S_F1;
      S_ALUC: nxt = S_WB;
      S_LD1:  nxt = S_LD2;
      S_LD2:  nxt = S_LD3;
      S_LD3:  nxt = S_F1;
      S_ST1:  nxt = S_ST2;
      S_ST2:  nxt = S_ST3;
      S_ST3:  nxt = S_F1;
      S_JMP:  nxt = S_F1;
      S_HALT: nxt = S_HALT;
      // Unused encodings recover through RST
      default: nxt = S_RST;
    endcase
  end

  always_comb begin
    wpc      = 1'b0;
    wmar     = 1'b0;
    wir      = 1'b0;
    wt       = 1'b0;
    wmdr     = 1'b0;
    rpc      = 1'b0;
    rt       = 1'b0;
    rc1      = 1'b0;
    rmar     = 1'b0;
    rmdr     = 1'b0;
    rm       = 1'b0;
    wmem     = 1'b0;
    in_mdr1  = 1'b0;
    in_mdr2  = 1'b0;
    out_mdr1 = 1'b0;
    out_mdr2 = 1'b0;
    inReg    = SEL_RD;
    wReg     = 1'b0;
    rReg     = 1'b0;
    aluOp    = ALU_PASS;
    ldF      = 1'b0;
    case (cur)
      S_F1: begin
        // PC to MAR while T captures PC+1
        rpc   = 1'b1;
        wmar  = 1'b1;
        rmar  = 1'b1;
        aluOp = ALU_INC;
        wt    = 1'b1;
      end
      S_F2: begin
        rmar    = 1'b1;
        rm      = 1'b1;
        in_mdr1 = 1'b1;
        wmdr    = 1'b1;
      end
      S_F3: begin
        rt  = 1'b1;
        wpc = 1'b1;
      end
      S_F4: begin
        rmdr     = 1'b1;
        out_mdr1 = 1'b1;
        wir      = 1'b1;
      end
      S_ALU1: begin
        rReg  = 1'b1;
        inReg = SEL_RS;
        wt    = 1'b1;
      end
      S_ALU2: begin
        rReg  = 1'b1;
        inReg = SEL_RT;
        aluOp = operationcode[2:0];
        wt    = 1'b1;
        ldF   = 1'b1;
      end
      S_WB: begin
        rt    = 1'b1;
        wReg  = 1'b1;
        inReg = SEL_RD;
      end
      S_ALUC: begin
        rc1   = 1'b1;
        aluOp = operationcode[2:0];
        wt    = 1'b1;
        ldF   = 1'b1;
      end
      S_LD1: begin
        rReg  = 1'b1;
        inReg = SEL_RS;
        wmar  = 1'b1;
      end
      S_LD2: begin
        rmar    = 1'b1;
        rm      = 1'b1;
        in_mdr1 = 1'b1;
        wmdr    = 1'b1;
      end
      S_LD3: begin
        rmdr     = 1'b1;
        out_mdr1 = 1'b1;
        wReg     = 1'b1;
        inReg    = SEL_RD;
      end
      S_ST1: begin
        rReg  = 1'b1;
        inReg = SEL_RS;
        wmar  = 1'b1;
      end
      S_ST2: begin
        rReg    = 1'b1;
        inReg   = SEL_RT;
        in_mdr2 = 1'b1;
        wmdr    = 1'b1;
      end
      S_ST3: begin
        rmar     = 1'b1;
        rmdr     = 1'b1;
        out_mdr2 = 1'b1;
        wmem     = 1'b1;
      end
      S_JMP: begin
        rReg  = 1'b1;
        inReg = SEL_RS;
        wpc   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state      = cur;
  assign next_state = nxt;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the controller microsequencer.
// Walks each instruction class and checks strobes per state.
module tb_controller;

  logic       clk;
  logic       reset;
  logic [5:0] operationcode;
  logic [4:0] state;
  logic [4:0] next_state;
  logic       wpc, wmar, wir, wt, wmdr;
  logic       rpc, rt, rc1, rmar, rmdr;
  logic       rm, wmem;
  logic       in_mdr1, in_mdr2;
  logic       out_mdr1, out_mdr2;
  logic [1:0] inReg;
  logic       wReg, rReg;
  logic [2:0] aluOp;
  logic       ldF;

  int n_cmp;
  int n_bad;

  localparam int WPC  = 1 << 18;
  localparam int WMAR = 1 << 17;
  localparam int WIR  = 1 << 16;
  localparam int WT   = 1 << 15;
  localparam int WMDR = 1 << 14;
  localparam int RPC  = 1 << 13;
  localparam int RT   = 1 << 12;
  localparam int RC1  = 1 << 11;
  localparam int RMAR = 1 << 10;
  localparam int RMDR = 1 << 9;
  localparam int RM   = 1 << 8;
  localparam int WMEM = 1 << 7;
  localparam int IN1  = 1 << 6;
  localparam int IN2  = 1 << 5;
  localparam int OUT1 = 1 << 4;
  localparam int OUT2 = 1 << 3;
  localparam int WREG = 1 << 2;
  localparam int RREG = 1 << 1;
  localparam int LDF  = 1 << 0;

  logic [18:0] ctl;
  assign ctl = {wpc, wmar, wir, wt, wmdr, rpc, rt, rc1,
                rmar, rmdr, rm, wmem, in_mdr1, in_mdr2,
                out_mdr1, out_mdr2, wReg, rReg, ldF};

  controller dut (
    .clk(clk),
    .reset(reset),
    .operationcode(operationcode),
    .state(state),
    .next_state(next_state),
    .wpc(wpc),
    .wmar(wmar),
    .wir(wir),
    .wt(wt),
    .wmdr(wmdr),
    .rpc(rpc),
    .rt(rt),
    .rc1(rc1),
    .rmar(rmar),
    .rmdr(rmdr),
    .rm(rm),
    .wmem(wmem),
    .in_mdr1(in_mdr1),
    .in_mdr2(in_mdr2),
    .out_mdr1(out_mdr1),
    .out_mdr2(out_mdr2),
    .inReg(inReg),
    .wReg(wReg),
    .rReg(rReg),
    .aluOp(aluOp),
    .ldF(ldF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag,
                           input int st,
                           input int c,
                           input int inr,
                           input int aop,
                           input int nst);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    chk({tag, ".inReg"}, 32'(inReg), 32'(inr));
    chk({tag, ".aluOp"}, 32'(aluOp), 32'(aop));
    chk({tag, ".next"}, 32'(next_state), 32'(nst));
  endtask

  // Starts in F1, ends sampled in DEC
  task automatic fetch(input logic [5:0] op);
    operationcode = op;
    expect_st("F1", 1, RPC|WMAR|RMAR|WT, 0, 4, 2);
    step();
    expect_st("F2", 2, RMAR|RM|IN1|WMDR, 0, 5, 3);
    step();
    expect_st("F3", 3, RT|WPC, 0, 5, 4);
    step();
    expect_st("F4", 4, RMDR|OUT1|WIR, 0, 5, 5);
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    operationcode = 6'b000000;
    step();
    expect_st("RST", 0, 0, 0, 5, 1);
    reset = 1'b0;
    step();

    fetch(6'b000011);
    expect_st("OR.DEC", 5, 0, 0, 5, 6);
    step();
    expect_st("OR.ALU1", 6, RREG|WT, 1, 5, 7);
    step();
    expect_st("OR.ALU2", 7, RREG|WT|LDF, 2, 3, 8);
    step();
    expect_st("OR.WB", 8, RT|WREG, 0, 5, 1);
    operationcode = 6'b111111;
    #1;
    chk("WB.opc_ignored", 32'(next_state), 32'd1);
    step();

    fetch(6'b010100);
    expect_st("INC.DEC", 5, 0, 0, 5, 6);
    step();
    expect_st("INC.ALU1", 6, RREG|WT, 1, 5, 9);
    step();
    expect_st("INC.ALUC", 9, RC1|WT|LDF, 0, 4, 8);
    step();
    expect_st("INC.WB", 8, RT|WREG, 0, 5, 1);
    step();

    fetch(6'b100000);
    expect_st("LD.DEC", 5, 0, 0, 5, 10);
    step();
    expect_st("LD1", 10, RREG|WMAR, 1, 5, 11);
    step();
    expect_st("LD2", 11, RMAR|RM|IN1|WMDR, 0, 5, 12);
    step();
    expect_st("LD3", 12, RMDR|OUT1|WREG, 0, 5, 1);
    step();

    fetch(6'b100001);
    expect_st("ST.DEC", 5, 0, 0, 5, 13);
    step();
    expect_st("ST1", 13, RREG|WMAR, 1, 5, 14);
    step();
    expect_st("ST2", 14, RREG|IN2|WMDR, 2, 5, 15);
    step();
    expect_st("ST3", 15, RMAR|RMDR|OUT2|WMEM, 0, 5, 1);
    step();

    fetch(6'b110000);
    expect_st("JMP.DEC", 5, 0, 0, 5, 16);
    step();
    expect_st("JMP", 16, RREG|WPC, 1, 5, 1);
    step();

    fetch(6'b110111);
    expect_st("XOR.DEC", 5, 0, 0, 5, 16);
    step();
    chk("JMP2.state", 32'(state), 32'd16);
    step();

    fetch(6'b111111);
    expect_st("HLT.DEC", 5, 0, 0, 5, 31);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_st("HALT", 31, 0, 0, 5, 31);
    end
    reset = 1'b1;
    step();
    expect_st("HLT.RST", 0, 0, 0, 5, 1);
    reset = 1'b0;
    step();

    fetch(6'b000111);
    step();
    step();
    expect_st("XOR.ALU2", 7, RREG|WT|LDF, 2, 7, 8);
    reset = 1'b1;
    step();
    expect_st("ABORT", 0, 0, 0, 5, 1);
    chk("ABORT.wReg", 32'(wReg), 32'd0);
    reset = 1'b0;
    step();
    expect_st("ABORT.F1", 1, RPC|WMAR|RMAR|WT, 0, 4, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
